usb_gpx_event_ctrl: RTL and testbench

- Avalon-MM slave controller for the USB controller's GPX status pin.
- Synchronises and glitch-filters the pin, detects programmable edges, latches them in a write-1-to-clear capture bit and counts events.
- Raises a maskable level interrupt to the Nios II, so GPX becomes interrupt-driven instead of software-polled.
- Sits between the top-level GPX pin and the SoC interconnect.

---
 rtl/usb_gpx_event_ctrl.sv | 136 +++++++++++++
 tb/tb_usb_gpx_event_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_gpx_event_ctrl.sv
// Avalon-MM slave for the USB GPX status pin: synchroniser, glitch filter,
// programmable edge capture, saturating event counter and maskable level irq.
module usb_gpx_event_ctrl #(
  parameter int FILT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        in_port,
  output logic        irq
);

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_CAPTURE = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;
  localparam logic [2:0] ADDR_FILTER  = 3'd4;

  logic              sync1;
  logic              sync_lvl;
  logic              filt;
  logic [FILT_W-1:0] fcnt;
  logic [FILT_W-1:0] filt_len;
  logic              enable;
  logic              irq_mask;
  logic [1:0]        edge_sel;
  logic              capture;
  logic [CNT_W-1:0]  count;

  logic              wr_en;
  logic              trans;
  logic              event_hit;
  logic              clr_count;
  logic [31:0]       rd_next;
  logic              unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign clr_count = wr_en && (address == ADDR_COUNT);
  assign unused_wd = ^writedata;

  // A transition is committed once the disagreement has lasted filt_len+1 compares.
  assign trans     = (sync_lvl != filt) && (fcnt >= filt_len);
  assign event_hit = trans && enable && (filt ? edge_sel[1] : edge_sel[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync_lvl <= 1'b0;
      filt     <= 1'b0;
      fcnt     <= '0;
    end else begin
      sync1    <= in_port;
      sync_lvl <= sync1;
      if (sync_lvl == filt) begin
        fcnt <= '0;
      end else if (trans) begin
        filt <= sync_lvl;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b0;
      irq_mask <= 1'b0;
      edge_sel <= 2'b00;
      filt_len <= '0;
    end else if (wr_en) begin
      if (address == ADDR_CONTROL) begin
        enable   <= writedata[0];
        irq_mask <= writedata[1];
        edge_sel <= writedata[3:2];
      end
      if (address == ADDR_FILTER) begin
        filt_len <= writedata[FILT_W-1:0];
      end
    end
  end

  // A new event always beats a same-cycle clear, for both capture and count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture <= 1'b0;
    end else if (event_hit) begin
      capture <= 1'b1;
    end else if (wr_en && (address == ADDR_CAPTURE) && writedata[0]) begin
      capture <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (event_hit) begin
      if (clr_count) begin
        count <= CNT_W'(1);
      end else if (!(&count)) begin
        count <= count + CNT_W'(1);
      end
    end else if (clr_count) begin
      count <= '0;
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      ADDR_STATUS:  rd_next[1:0] = {sync_lvl, filt};
      ADDR_CONTROL: rd_next[3:0] = {edge_sel, irq_mask, enable};
      ADDR_CAPTURE: rd_next[0] = capture;
      ADDR_COUNT:   rd_next[CNT_W-1:0] = count;
      ADDR_FILTER:  rd_next[FILT_W-1:0] = filt_len;
      default:      rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

  // Both operands are flops, so the bus cannot reach irq combinationally.
  assign irq = capture & irq_mask;

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Self-checking bench for usb_gpx_event_ctrl: directed scenarios plus a randomized
// run, all compared against a pin-history reference model.
module tb_usb_gpx_event_ctrl;

  localparam int FILT_W  = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int HIST    = 40;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        in_port = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  usb_gpx_event_ctrl #(.FILT_W(FILT_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .in_port(in_port),
    .irq(irq)
  );

  // Reference model: the filtered level flips once the last filt_len+1 synchronised
  // pin samples all disagree with it. hist[0] is the pin at the previous edge.
  bit          hist [HIST];
  bit          m_filt, m_en, m_mask, m_cap;
  bit [1:0]    m_sel;
  int          m_len, m_cnt;
  logic [31:0] m_rd;

  initial forever begin
    bit flip, ev, wr;
    int base;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int i = 0; i < HIST; i++) hist[i] = 1'b0;
      m_filt = 0; m_en = 0; m_mask = 0; m_cap = 0; m_sel = 2'b00;
      m_len = 0; m_cnt = 0; m_rd = 32'd0;
    end else begin
      case (address)
        3'd0: m_rd = {30'd0, hist[1], m_filt};
        3'd1: m_rd = {28'd0, m_sel, m_mask, m_en};
        3'd2: m_rd = {31'd0, m_cap};
        3'd3: m_rd = 32'(m_cnt);
        3'd4: m_rd = 32'(m_len);
        default: m_rd = 32'd0;
      endcase
      flip = 1;
      for (int i = 0; i <= m_len; i++) if (hist[1+i] == m_filt) flip = 0;
      ev = flip && m_en && (m_filt ? m_sel[1] : m_sel[0]);
      wr = chipselect && !write_n;
      if (wr && address == 3'd2 && writedata[0]) m_cap = 0;
      if (ev) m_cap = 1;
      base = (wr && address == 3'd3) ? 0 : m_cnt;
      if (ev && base < CNT_MAX) base++;
      m_cnt = base;
      if (wr && address == 3'd1) {m_sel, m_mask, m_en} = writedata[3:0];
      if (wr && address == 3'd4) m_len = int'(writedata[7:0]);
      if (flip) m_filt = !m_filt;
      for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = in_port;
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic [31:0] e);
    address = a;
    @(posedge clk);
    #1;
    d = readdata;
    e = m_rd;
    @(negedge clk);
  endtask

  task automatic pulse(input int hi, input int lo);
    in_port = 1'b1; idle(hi);
    in_port = 1'b0; idle(lo);
  endtask

  task automatic test_reset;
    logic [31:0] d, e;
    reset_n = 1'b0; in_port = 1'b1;
    idle(3);
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    reset_n = 1'b1;
    wr(3'd1, 32'hF);
    wr(3'd4, 32'h3);
    rd(3'd2, d, e);
    checks++; if (d !== 32'd0 || d !== e) begin errors++; $display("FAIL rst_capture got %h want 0 model %h", d, e); end
    rd(3'd3, d, e);
    checks++; if (d !== 32'd0 || d !== e) begin errors++; $display("FAIL rst_count got %h want 0 model %h", d, e); end
    rd(3'd1, d, e);
    checks++; if (d !== 32'hF || d !== e) begin errors++; $display("FAIL rst_control got %h want f", d); end
    rd(3'd4, d, e);
    checks++; if (d !== 32'h3 || d !== e) begin errors++; $display("FAIL rst_filter got %h want 3", d); end
    idle(2);
    rd(3'd0, d, e);
    checks++; if (d !== 32'h3 || d !== e) begin errors++; $display("FAIL rst_status got %h want 3", d); end
    checks++; if (irq !== (m_cap & m_mask)) begin errors++; $display("FAIL rst_irq_after got %b want %b", irq, m_cap & m_mask); end
  endtask

  task automatic test_filter_boundary;
    logic [31:0] d, e;
    in_port = 1'b0;
    wr(3'd1, 32'h7);
    idle(8);
    wr(3'd2, 32'h1);
    wr(3'd3, 32'h0);
    pulse(3, 10);
    rd(3'd0, d, e);
    checks++; if (d !== 32'd0 || d !== e) begin errors++; $display("FAIL glitch_status got %h want 0", d); end
    rd(3'd2, d, e);
    checks++; if (d !== 32'd0 || d !== e) begin errors++; $display("FAIL glitch_capture got %h want 0", d); end
    rd(3'd3, d, e);
    checks++; if (d !== 32'd0 || d !== e) begin errors++; $display("FAIL glitch_count got %h want 0", d); end
    in_port = 1'b1;
    idle(4);
    in_port = 1'b0;
    idle(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pulse_irq_early got %b want 0", irq); end
    rd(3'd0, d, e);
    checks++; if (d !== 32'h2 || d !== e) begin errors++; $display("FAIL pulse_status_pre got %h want 2", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pulse_irq got %b want 1", irq); end
    rd(3'd0, d, e);
    checks++; if (d !== 32'h1 || d !== e) begin errors++; $display("FAIL pulse_status_post got %h want 1", d); end
    rd(3'd2, d, e);
    checks++; if (d !== 32'h1 || d !== e) begin errors++; $display("FAIL pulse_capture got %h want 1", d); end
    rd(3'd3, d, e);
    checks++; if (d !== 32'h1 || d !== e) begin errors++; $display("FAIL pulse_count got %h want 1", d); end
    idle(8);
  endtask

  task automatic test_edge_mask;
    logic [31:0] d, e;
    wr(3'd4, 32'h0);
    wr(3'd1, 32'hB);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'h1);
    for (int i = 0; i < 5; i++) pulse(3, 3);
    idle(2);
    rd(3'd3, d, e);
    checks++; if (d !== 32'd5 || d !== e) begin errors++; $display("FAIL fall_count got %h want 5", d); end
    wr(3'd1, 32'hF);
    for (int i = 0; i < 5; i++) pulse(3, 3);
    idle(2);
    rd(3'd3, d, e);
    checks++; if (d !== 32'd15 || d !== e) begin errors++; $display("FAIL both_count got %h want f", d); end
    wr(3'd1, 32'hD);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got %b want 0", irq); end
    rd(3'd2, d, e);
    checks++; if (d !== 32'h1 || d !== e) begin errors++; $display("FAIL masked_capture got %h want 1", d); end
    wr(3'd2, 32'h1);
    rd(3'd2, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL w1c_capture got %h want 0", d); end
  endtask

  task automatic test_collision;
    logic [31:0] d, e;
    wr(3'd1, 32'hF);
    pulse(3, 3);
    wr(3'd3, 32'h0);
    in_port = 1'b1;
    idle(2);
    wr(3'd2, 32'h1);
    rd(3'd2, d, e);
    checks++; if (d !== 32'h1 || d !== e) begin errors++; $display("FAIL coll_capture got %h want 1", d); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL coll_irq got %b want 1", irq); end
    in_port = 1'b0;
    idle(2);
    wr(3'd3, 32'h0);
    rd(3'd3, d, e);
    checks++; if (d !== 32'h1 || d !== e) begin errors++; $display("FAIL coll_count got %h want 1", d); end
  endtask

  task automatic test_saturation;
    logic [31:0] d, e;
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h7);
    for (int i = 0; i < 20; i++) pulse(2, 3);
    rd(3'd3, d, e);
    checks++; if (d !== 32'(CNT_MAX) || d !== e) begin errors++; $display("FAIL sat_count got %h want %h", d, CNT_MAX); end
    wr(3'd3, 32'h0);
    rd(3'd3, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL sat_clear got %h want 0", d); end
  endtask

  task automatic test_random;
    int run = 0;
    logic [2:0] a;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (run == 0) begin
        in_port = 1'($urandom_range(0, 1));
        run = int'($urandom_range(1, 6));
      end
      run--;
      a = 3'($urandom_range(0, 7));
      address = a;
      if ($urandom_range(0, 9) == 0) begin
        chipselect = 1'b1; write_n = 1'b0;
        writedata = (a == 3'd4) ? 32'($urandom_range(0, 4)) : $urandom;
      end else begin
        chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1; writedata = $urandom;
      end
      @(negedge clk);
      checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata cyc %0d got %h want %h", cyc, readdata, m_rd); end
      checks++; if (irq !== (m_cap & m_mask)) begin errors++; $display("FAIL rand_irq cyc %0d got %b want %b", cyc, irq, m_cap & m_mask); end
    end
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0; in_port = 1'b0;
    wr(3'd4, 32'h0);
    idle(10);
  endtask

  task automatic test_enable_reset;
    logic [31:0] d, e;
    wr(3'd1, 32'hC);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'h1);
    for (int i = 0; i < 3; i++) begin
      in_port = 1'b1; idle(4);
      rd(3'd0, d, e);
      checks++; if (d !== 32'h3 || d !== e) begin errors++; $display("FAIL dis_status_hi got %h want 3", d); end
      in_port = 1'b0; idle(4);
      rd(3'd0, d, e);
      checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL dis_status_lo got %h want 0", d); end
    end
    rd(3'd3, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL dis_count got %h want 0", d); end
    rd(3'd2, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL dis_capture got %h want 0", d); end
    wr(3'd1, 32'hF);
    pulse(3, 3);
    wr(3'd4, 32'h3);
    in_port = 1'b1;
    idle(4);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b want 1", irq); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL async_readdata got %h want 0", readdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq got %b want 0", irq); end
    idle(2);
    reset_n = 1'b1;
    rd(3'd1, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL post_control got %h want 0", d); end
    rd(3'd4, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL post_filter got %h want 0", d); end
    idle(6);
    rd(3'd0, d, e);
    checks++; if (d !== 32'h3 || d !== e) begin errors++; $display("FAIL post_status got %h want 3", d); end
    rd(3'd2, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL post_capture got %h want 0", d); end
    rd(3'd3, d, e);
    checks++; if (d !== 32'h0 || d !== e) begin errors++; $display("FAIL post_count got %h want 0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL post_irq got %b want 0", irq); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_filter_boundary();
    test_edge_mask();
    test_collision();
    test_saturation();
    test_random();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
